// File: rtl/bus_memory_loader.sv
// Bus-attached RAM with address register and auto-increment.
// Self-sequenced LOAD (valid/ready stream) and CLEAR modes.
module bus_memory_loader #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int DEPTH      = 1 << ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] bus,
   input  logic                  en_write_mem_adr,
   input  logic                  en_write_mem,
   input  logic                  en_increment_adr,
   output logic [DATA_WIDTH-1:0] last_read,
   output logic [ADDR_WIDTH-1:0] adr,
   input  logic                  prog_mode,
   input  logic                  load_valid,
   input  logic [DATA_WIDTH-1:0] load_data,
   output logic                  load_ready,
   output logic                  load_done,
   input  logic                  clear_req,
   output logic                  busy
);

   localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

   typedef enum logic [1:0] {RUN, LOAD, DONE, CLEAR} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] ptr;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  we;
   logic [ADDR_WIDTH-1:0] waddr;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  accept;

   // Dropping prog_mode must refuse the word offered in the abort cycle.
   assign load_ready = (state == LOAD) && prog_mode;
   assign accept     = load_ready && load_valid;

   always_comb begin
      we    = 1'b0;
      waddr = adr;
      wdata = bus;
      unique case (state)
         RUN: begin
            we = en_write_mem && !en_write_mem_adr;
         end
         LOAD: begin
            we    = accept;
            waddr = ptr;
            wdata = load_data;
         end
         CLEAR: begin
            we    = 1'b1;
            waddr = ptr;
            wdata = '0;
         end
         default: ;
      endcase
      we = we && reset_n;
   end

   // Array is deliberately outside the reset domain: contents survive reset.
   always_ff @(posedge clk) begin
      if (we && ({1'b0, waddr} < DEPTH_W))
         mem[waddr] <= wdata;
   end

   assign last_read = ({1'b0, adr} < DEPTH_W) ? mem[adr] : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= RUN;
         adr       <= '0;
         ptr       <= '0;
         busy      <= 1'b0;
         load_done <= 1'b0;
      end else begin
         unique case (state)
            RUN: begin
               if (en_write_mem_adr)
                  adr <= bus[ADDR_WIDTH-1:0];
               else if (en_increment_adr)
                  adr <= (adr == LAST) ? '0 : adr + 1'b1;
               if (prog_mode) begin
                  state <= LOAD;
                  ptr   <= '0;
                  busy  <= 1'b1;
               end else if (clear_req) begin
                  state <= CLEAR;
                  ptr   <= '0;
                  busy  <= 1'b1;
               end
            end
            LOAD: begin
               if (!prog_mode) begin
                  state <= RUN;
                  adr   <= '0;
                  busy  <= 1'b0;
               end else if (load_valid) begin
                  ptr <= ptr + 1'b1;
                  if (ptr == LAST) begin
                     state     <= DONE;
                     load_done <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (!prog_mode) begin
                  state     <= RUN;
                  adr       <= '0;
                  busy      <= 1'b0;
                  load_done <= 1'b0;
               end
            end
            CLEAR: begin
               ptr <= ptr + 1'b1;
               if (ptr == LAST) begin
                  state <= RUN;
                  adr   <= '0;
                  busy  <= 1'b0;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_memory_loader.sv
// Directed bench for bus_memory_loader (DEPTH=16): RUN ops, LOAD, abort, CLEAR, async reset.
module tb_bus_memory_loader;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] bus;
   logic       en_write_mem_adr, en_write_mem, en_increment_adr;
   logic [7:0] last_read;
   logic [3:0] adr;
   logic       prog_mode, load_valid;
   logic [7:0] load_data;
   logic       load_ready, load_done, clear_req, busy;

   int total = 0;
   int bad   = 0;
   int cnt;

   bus_memory_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus),
      .en_write_mem_adr(en_write_mem_adr), .en_write_mem(en_write_mem),
      .en_increment_adr(en_increment_adr), .last_read(last_read), .adr(adr),
      .prog_mode(prog_mode), .load_valid(load_valid), .load_data(load_data),
      .load_ready(load_ready), .load_done(load_done), .clear_req(clear_req),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_adr(input logic [3:0] a);
      bus = {4'h0, a};
      en_write_mem_adr = 1'b1;
      step();
      en_write_mem_adr = 1'b0;
   endtask

   task automatic rd(input string tag, input int i, input logic [7:0] e);
      set_adr(4'(i));
      chk(tag, last_read, e);
   endtask

   task automatic full_load(input logic [7:0] base);
      prog_mode = 1'b1;
      step();
      for (int i = 0; i < 16; i++) begin
         load_valid = 1'b1;
         load_data  = base + 8'(i);
         chk("load_ready_stream", load_ready, 1'b1);
         step();
      end
      load_valid = 1'b0;
      chk("load_done_set", load_done, 1'b1);
      chk("load_ready_done", load_ready, 1'b0);
      prog_mode = 1'b0;
      step();
      chk("exit_done_busy", busy, 1'b0);
      chk("exit_done_adr", adr, 4'h0);
   endtask

   initial begin
      reset_n = 1'b0; bus = '0; en_write_mem_adr = 0; en_write_mem = 0;
      en_increment_adr = 0; prog_mode = 0; load_valid = 0; load_data = '0;
      clear_req = 0;
      step(); step();
      chk("rst_adr", adr, 4'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_load_ready", load_ready, 1'b0);
      chk("rst_load_done", load_done, 1'b0);
      reset_n = 1'b1;
      step();

      // RUN basic
      set_adr(4'h3);
      chk("run_adr3", adr, 4'h3);
      bus = 8'hA5; en_write_mem = 1'b1;
      step();
      en_write_mem = 1'b0;
      chk("run_write_a5", last_read, 8'hA5);
      bus = 8'h07; en_write_mem_adr = 1'b1; en_write_mem = 1'b1;
      step();
      en_write_mem_adr = 1'b0; en_write_mem = 1'b0;
      chk("prio_adr7", adr, 4'h7);
      rd("prio_no_write", 3, 8'hA5);

      // Auto-increment with wrap
      set_adr(4'hF);
      bus = 8'h11; en_write_mem = 1'b1; en_increment_adr = 1'b1;
      step();
      en_write_mem = 1'b0; en_increment_adr = 1'b0;
      chk("inc_wrap_adr", adr, 4'h0);
      rd("inc_data15", 15, 8'h11);

      // Full LOAD, then read back via auto-increment
      prog_mode = 1'b1;
      step();
      chk("load_busy", busy, 1'b1);
      chk("load_ready_hi", load_ready, 1'b1);
      for (int i = 0; i < 16; i++) begin
         load_valid = 1'b1;
         load_data  = 8'h10 + 8'(i);
         chk("full_ready", load_ready, 1'b1);
         chk("full_no_done_yet", load_done, 1'b0);
         step();
      end
      load_valid = 1'b0;
      chk("full_done", load_done, 1'b1);
      chk("full_ready_lo", load_ready, 1'b0);
      chk("full_busy_done", busy, 1'b1);
      prog_mode = 1'b0;
      step();
      chk("full_exit_busy", busy, 1'b0);
      chk("full_exit_adr", adr, 4'h0);
      chk("full_exit_done", load_done, 1'b0);
      for (int i = 0; i < 16; i++) begin
         chk("full_readback", last_read, 8'h10 + 8'(i));
         en_increment_adr = 1'b1;
         step();
         en_increment_adr = 1'b0;
      end

      // Handshake gaps, then abort after 5 words
      prog_mode = 1'b1;
      step();
      for (int c = 0; c < 10; c++) begin
         load_valid = (c % 2 == 0);
         load_data  = 8'hC0 + 8'(c / 2);
         step();
      end
      prog_mode = 1'b0; load_valid = 1'b1; load_data = 8'hEE;
      #1;
      chk("abort_ready_lo", load_ready, 1'b0);
      step();
      load_valid = 1'b0;
      chk("abort_busy", busy, 1'b0);
      chk("abort_adr", adr, 4'h0);
      chk("abort_done", load_done, 1'b0);
      for (int i = 0; i < 16; i++)
         rd("abort_data", i, (i < 5) ? 8'hC0 + 8'(i) : 8'h10 + 8'(i));

      // CLEAR after a full load; stray en_write_mem must be ignored
      full_load(8'h30);
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      cnt = 0;
      while (busy && cnt < 40) begin
         cnt++;
         if (cnt == 5) begin bus = 8'h77; en_write_mem = 1'b1; end
         step();
         en_write_mem = 1'b0;
      end
      chk("clear_cycles", cnt, 16);
      chk("clear_adr", adr, 4'h0);
      for (int i = 0; i < 16; i++)
         rd("clear_data", i, 8'h00);

      // Async reset mid-CLEAR at pointer 7
      full_load(8'h50);
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      for (int i = 0; i < 7; i++) step();
      chk("pre_reset_busy", busy, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      chk("areset_busy", busy, 1'b0);
      chk("areset_adr", adr, 4'h0);
      step(); step();
      reset_n = 1'b1;
      step();
      chk("post_reset_busy", busy, 1'b0);
      for (int i = 0; i < 16; i++)
         rd("areset_data", i, (i < 7) ? 8'h00 : 8'h50 + 8'(i));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bus_memory_loader.md
Name: bus_memory_loader

Overview:
- Parametrised successor of the machine's bus-attached RAM.
- Provides an address register and a DEPTH x DATA_WIDTH array on the shared bus, with an address auto-increment control.
- Adds two self-sequenced modes: a LOAD mode that fills memory from an external valid/ready stream (front-panel or host programming), and a CLEAR mode that zeroes the array.
- Sits beside the A/B/PC/IR registers; the microcode drives the RUN-mode controls.

Parameters:
- DATA_WIDTH, 8, bus and word width.
- ADDR_WIDTH, 4, address register width.
- DEPTH, 1<<ADDR_WIDTH, number of words; must not exceed 1<<ADDR_WIDTH.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- bus  in  DATA_WIDTH  value currently driven on the shared bus.
- en_write_mem_adr  in  1  load the address register from bus.
- en_write_mem  in  1  write bus into data[adr].
- en_increment_adr  in  1  adr <= adr+1 (wraps).
- last_read  out  DATA_WIDTH  data[adr], combinational.
- adr  out  ADDR_WIDTH  current address register.
- prog_mode  in  1  level; high requests LOAD mode.
- load_valid  in  1  load_data is valid.
- load_data  in  DATA_WIDTH  word to store.
- load_ready  out  1  block accepts load_data this cycle.
- load_done  out  1  all DEPTH words loaded.
- clear_req  in  1  pulse; request CLEAR.
- busy  out  1  high in any state other than RUN.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=RUN, adr=0, load pointer=0, clear pointer=0.
  - load_ready=0, load_done=0, busy=0.
  - Array contents are not reset.
- States: RUN, LOAD, DONE, CLEAR.
- RUN:
  - Priority: en_write_mem_adr (adr <= bus[ADDR_WIDTH-1:0]) > en_write_mem/en_increment_adr.
  - en_write_mem together with en_increment_adr: write at the old adr, then adr+1.
  - Increment wraps DEPTH-1 -> 0 (also when DEPTH < 2^ADDR_WIDTH).
  - prog_mode=1 -> LOAD with load pointer=0. prog_mode has priority over clear_req in the same cycle.
  - clear_req=1 (and prog_mode=0) -> CLEAR with clear pointer=0.
- LOAD:
  - load_ready=1. RUN-mode controls are ignored.
  - On load_valid & load_ready: data[ptr] <= load_data, ptr++. Writes take one cycle; the next word can be accepted on the next cycle (full throughput).
  - Acceptance at ptr==DEPTH-1 -> DONE.
  - prog_mode=0 before completion -> abort to RUN:
    - partial contents retained;
    - load_done=0;
    - adr=0;
    - a word offered in the abort cycle is not accepted (load_ready is driven 0 when prog_mode=0).
- DONE:
  - load_done=1, load_ready=0.
  - Stays until prog_mode=0, then -> RUN with adr=0.
  - load_done clears on leaving DONE.
- CLEAR:
  - Writes 0 to data[clear pointer] each cycle, pointer++.
  - After writing DEPTH-1 -> RUN with adr=0.
  - Takes exactly DEPTH cycles. clear_req and prog_mode are ignored while in CLEAR. RUN-mode controls are ignored.
- busy=1 in LOAD, DONE, CLEAR; 0 in RUN (registered with state).
- last_read always reflects data[adr], including just after writes (new value visible the cycle after the write edge).
- Reset asserted mid-LOAD or mid-CLEAR: immediate return to reset state. Words already written are kept; the remaining words are untouched.

Test Plan:
- RUN basic:
  - Stimulus: bus=0x03 with en_write_mem_adr; then bus=0xA5 with en_write_mem.
  - Required: adr=3, then last_read=0xA5.
  - Stimulus: en_write_mem_adr and en_write_mem together.
  - Required: only adr changes.
- Auto-increment:
  - Stimulus: adr=15, then bus=0x11 with en_write_mem and en_increment_adr.
  - Required: data[15]=0x11 and adr=0 (wrap).
- Full LOAD (DEPTH=16):
  - Stimulus: prog_mode=1; stream 0x10..0x1F with load_valid held high.
  - Required: 16 accepts in 16 consecutive cycles; load_done=1, load_ready=0.
  - Stimulus: drop prog_mode, read all addresses.
  - Required: busy=0, adr=0, data[i]=0x10+i.
- Handshake gaps and abort:
  - Stimulus: toggle load_valid 1/0; drop prog_mode after 5 words.
  - Required: only addresses 0..4 written, load_done=0, state RUN, adr=0.
- CLEAR:
  - Stimulus: pulse clear_req after a full load.
  - Required: busy high for exactly 16 cycles; all words 0x00; en_write_mem pulsed during CLEAR has no effect.
- Async reset:
  - Stimulus: reset_n low mid-CLEAR (pointer=7), between clock edges.
  - Required: busy=0 and adr=0 immediately; words 0..6 are 0x00; words 7..15 hold their pre-clear values.
